// File: rtl/conv_stream_driver.sv
// conv_stream_driver
// Host-side front end for the 2-channel conv accelerator.
// - The host loads one job (two 8x8 IFMDs and four 3x3/5x5 kernels) into a
//   local source RAM, then pulses start.
// - The job is streamed out on din/in_st_ifmd/in_st_kw with kw_is_5_5.
// - The two OFMD result streams, qualified by out_st, are captured into
//   result RAMs that the host can read back.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cfg_5x5              kernel size for the job (1 = 5x5), latched on start
//   src_we/addr/wdata    host write port into the source RAM (IDLE only)
//   start                launch a job (ignored while busy)
//   busy, done           job status; done held until the next accepted start
//   timeout_err          result stream missing or stalled, raised with done
//   din, in_st_ifmd,
//   in_st_kw, kw_is_5_5  stream towards the accelerator
//   out_st, dout_ofmd1/2 result stream from the accelerator
//   res_rd_addr/data1/2  host read port into the result RAMs, 1-cycle latency
module conv_stream_driver #(
  parameter int IFMD_WORDS     = 64,
  parameter int KW_WORDS_3     = 9,
  parameter int KW_WORDS_5     = 25,
  parameter int OFMD_WORDS_3   = 36,
  parameter int OFMD_WORDS_5   = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_5x5,
  input  logic        src_we,
  input  logic [7:0]  src_addr,
  input  logic [7:0]  src_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [7:0]  din,
  output logic        in_st_ifmd,
  output logic        in_st_kw,
  output logic        kw_is_5_5,
  input  logic        out_st,
  input  logic [15:0] dout_ofmd1,
  input  logic [15:0] dout_ofmd2,
  input  logic [5:0]  res_rd_addr,
  output logic [15:0] res_rd_data1,
  output logic [15:0] res_rd_data2
);

  typedef enum logic [2:0] {
    IDLE, PREFETCH, SEND_IFMD, GAP, SEND_KW, WAIT_OUT, CAPTURE, FIN
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  // Read-pointer values one past the last word of each section.
  localparam logic [7:0] IFMD_END = 8'(2 * IFMD_WORDS);
  localparam logic [7:0] KW_END_3 = 8'(2 * IFMD_WORDS + 4 * KW_WORDS_3);
  localparam logic [7:0] KW_END_5 = 8'(2 * IFMD_WORDS + 4 * KW_WORDS_5);
  localparam logic [5:0] CAP_LAST_3 = 6'(OFMD_WORDS_3 - 1);
  localparam logic [5:0] CAP_LAST_5 = 6'(OFMD_WORDS_5 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             cfg_lat;
  logic [7:0]       rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [5:0]       cap_cnt;

  logic [7:0]  src_mem  [256];
  logic [15:0] res_mem1 [64];
  logic [15:0] res_mem2 [64];

  logic [7:0] kw_end;
  logic [5:0] cap_last;
  logic       res_we;

  assign kw_end   = cfg_lat ? KW_END_5 : KW_END_3;
  assign cap_last = cfg_lat ? CAP_LAST_5 : CAP_LAST_3;
  assign res_we   = !rst && out_st && (state == WAIT_OUT || state == CAPTURE);

  // NOTE: RAM arrays carry no reset so they map onto block RAM; their
  // contents survive rst and only the control state is cleared.
  always_ff @(posedge clk) begin
    if (src_we && state == IDLE) src_mem[src_addr] <= src_wdata;
  end

  always_ff @(posedge clk) begin
    if (res_we) begin
      res_mem1[cap_cnt] <= dout_ofmd1;
      res_mem2[cap_cnt] <= dout_ofmd2;
    end
  end

  // Read port registers sample the array before a same-cycle write lands,
  // so a collision returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_rd_data1 <= '0;
      res_rd_data2 <= '0;
    end else begin
      res_rd_data1 <= res_mem1[res_rd_addr];
      res_rd_data2 <= res_mem2[res_rd_addr];
    end
  end

  // The din register doubles as the source RAM read register: the word at
  // rd_ptr is loaded on the same edge that raises the matching strobe.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_lat     <= 1'b0;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      cap_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      din         <= '0;
      in_st_ifmd  <= 1'b0;
      in_st_kw    <= 1'b0;
      kw_is_5_5   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PREFETCH;
            cfg_lat     <= cfg_5x5;
            rd_ptr      <= '0;
            cap_cnt     <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
          end
        end

        PREFETCH: begin
          din        <= src_mem[rd_ptr];
          rd_ptr     <= rd_ptr + 8'd1;
          in_st_ifmd <= 1'b1;
          kw_is_5_5  <= cfg_lat;
          state      <= SEND_IFMD;
        end

        SEND_IFMD: begin
          if (rd_ptr == IFMD_END) begin
            din        <= '0;
            in_st_ifmd <= 1'b0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else begin
            din    <= src_mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            din      <= src_mem[rd_ptr];
            rd_ptr   <= rd_ptr + 8'd1;
            in_st_kw <= 1'b1;
            state    <= SEND_KW;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        SEND_KW: begin
          if (rd_ptr == kw_end) begin
            din      <= '0;
            in_st_kw <= 1'b0;
            tmo_cnt  <= '0;
            state    <= WAIT_OUT;
          end else begin
            din    <= src_mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
          end
        end

        // Both states capture identically; CAPTURE only records that the
        // result stream has begun. The timeout restarts on every valid word.
        WAIT_OUT, CAPTURE: begin
          if (out_st) begin
            tmo_cnt <= '0;
            cap_cnt <= cap_cnt + 6'd1;
            if (cap_cnt == cap_last) begin
              state     <= FIN;
              busy      <= 1'b0;
              done      <= 1'b1;
              kw_is_5_5 <= 1'b0;
            end else begin
              state <= CAPTURE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            kw_is_5_5   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        FIN: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Bench for conv_stream_driver: random/ramp jobs, a queue of expected
// stream beats checked by an independent monitor, and result read-back.
module tb_conv_stream_driver;

  localparam int TIMEOUT = 4096;
  localparam int GAP     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_5x5 = 1'b0;
  logic        src_we = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  src_wdata = '0;
  logic        start = 1'b0;
  logic        busy, done, timeout_err;
  logic [7:0]  din;
  logic        in_st_ifmd, in_st_kw, kw_is_5_5;
  logic        out_st = 1'b0;
  logic [15:0] dout_ofmd1 = '0;
  logic [15:0] dout_ofmd2 = '0;
  logic [5:0]  res_rd_addr = '0;
  logic [15:0] res_rd_data1, res_rd_data2;

  conv_stream_driver dut (
    .clk(clk), .rst(rst), .cfg_5x5(cfg_5x5),
    .src_we(src_we), .src_addr(src_addr), .src_wdata(src_wdata),
    .start(start), .busy(busy), .done(done), .timeout_err(timeout_err),
    .din(din), .in_st_ifmd(in_st_ifmd), .in_st_kw(in_st_kw), .kw_is_5_5(kw_is_5_5),
    .out_st(out_st), .dout_ofmd1(dout_ofmd1), .dout_ofmd2(dout_ofmd2),
    .res_rd_addr(res_rd_addr), .res_rd_data1(res_rd_data1), .res_rd_data2(res_rd_data2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         kw;
    logic [7:0] data;
    int         at;
    bit         k55;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  src_model [256];
  logic [15:0] exp_res1  [64];
  logic [15:0] exp_res2  [64];
  int          done_cyc = -1;
  bit          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor: every strobed beat must match the next expected beat,
  // including the cycle it appears in; idle cycles must carry din = 0.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", {31'b0, in_st_ifmd & in_st_kw}, 32'd0);
      if (in_st_ifmd || in_st_kw) begin
        if (exp_q.size() == 0) begin
          check("stray_beat", {31'b0, in_st_ifmd | in_st_kw}, 32'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_kind",  {31'b0, in_st_kw}, {31'b0, b.kw});
          check("beat_din",   {24'b0, din}, {24'b0, b.data});
          check("beat_cycle", cyc, b.at);
          check("beat_kw55",  {31'b0, kw_is_5_5}, {31'b0, b.k55});
        end
      end else begin
        check("idle_din", {24'b0, din}, 32'd0);
      end
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_src(input bit ramp);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      src_we    = 1'b1;
      src_addr  = 8'(a);
      src_wdata = ramp ? 8'(a) : 8'($urandom);
      src_model[a] = src_wdata;
    end
    @(negedge clk);
    src_we = 1'b0;
  endtask

  // Pulses start (optionally with a same-cycle source write) and queues the
  // whole expected stream: 128 IFMD words from cycle s+2, a GAP-cycle hole,
  // then 4*N kernel words.
  task automatic start_job(input bit cfg, input bit wr_with_start, output int s);
    int n;
    @(negedge clk);
    start   = 1'b1;
    cfg_5x5 = cfg;
    if (wr_with_start) begin
      src_we    = 1'b1;
      src_addr  = 8'd5;
      src_wdata = 8'($urandom);
      src_model[5] = src_wdata;
    end
    s        = cyc;
    done_cyc = -1;
    n        = cfg ? 25 : 9;
    for (int i = 0; i < 128; i++)
      exp_q.push_back('{kw: 1'b0, data: src_model[i], at: s + 2 + i, k55: cfg});
    for (int i = 0; i < 4 * n; i++)
      exp_q.push_back('{kw: 1'b1, data: src_model[128 + i], at: s + 2 + 128 + GAP + i, k55: cfg});
    @(negedge clk);
    start   = 1'b0;
    src_we  = 1'b0;
    cfg_5x5 = ~cfg;
    check("busy_on_start", {31'b0, busy}, 32'd1);
    check("done_clr_on_start", {31'b0, done}, 32'd0);
    check("tmo_clr_on_start", {31'b0, timeout_err}, 32'd0);
  endtask

  // mode 0: M contiguous words base+k / -(base+k)
  // mode 1: 40 random words in bursts of 5 with 3-cycle holes
  // mode 2: out_st never asserted
  task automatic drive_out(input bit cfg, input int s, input int mode, input int base,
                           output int exp_done);
    int m, last_kw, v, c, total;
    logic [15:0] d1, d2;
    m       = cfg ? 16 : 36;
    last_kw = s + 2 + 128 + GAP + 4 * (cfg ? 25 : 9) - 1;
    total   = (mode == 0) ? m : 40;
    exp_done = -1;
    wait_until(last_kw + 4);
    if (mode == 2) begin
      exp_done = last_kw + 1 + TIMEOUT;
    end else begin
      v = 0;
      c = 0;
      while (v < total) begin
        if (mode == 1 && (c % 8) >= 5) begin
          out_st     = 1'b0;
          dout_ofmd1 = 16'($urandom);
          dout_ofmd2 = 16'($urandom);
        end else begin
          d1 = (mode == 0) ? 16'(base + v)    : 16'($urandom);
          d2 = (mode == 0) ? 16'(-(base + v)) : 16'($urandom);
          out_st     = 1'b1;
          dout_ofmd1 = d1;
          dout_ofmd2 = d2;
          if (v < m) begin
            exp_res1[v] = d1;
            exp_res2[v] = d2;
          end
          if (v == m - 1) exp_done = cyc + 1;
          v++;
        end
        c++;
        @(negedge clk);
      end
      out_st     = 1'b0;
      dout_ofmd1 = 16'($urandom);
      dout_ofmd2 = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int exp_cyc, input bit exp_tmo);
    int limit;
    limit = cyc + TIMEOUT + 600;
    while (done_cyc < 0 && cyc < limit) @(negedge clk);
    if (done_cyc < 0) begin
      check("done_seen", {31'b0, done}, 32'd1);
    end else begin
      check("done_cycle", done_cyc, exp_cyc);
      check("timeout_err", {31'b0, timeout_err}, {31'b0, exp_tmo});
      check("busy_at_done", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("kw55_idle", {31'b0, kw_is_5_5}, 32'd0);
      check("done_held", {31'b0, done}, 32'd1);
    end
    check("beats_left", exp_q.size(), 32'd0);
  endtask

  task automatic readback(input int m);
    for (int j = 0; j < m; j++) begin
      @(negedge clk);
      res_rd_addr = 6'(j);
      @(negedge clk);
      check("res_rd_data1", {16'b0, res_rd_data1}, {16'b0, exp_res1[j]});
      check("res_rd_data2", {16'b0, res_rd_data2}, {16'b0, exp_res2[j]});
    end
  endtask

  task automatic full_job(input bit cfg, input int mode, input int base, input bit wr_with_start);
    int s, ed;
    start_job(cfg, wr_with_start, s);
    drive_out(cfg, s, mode, base, ed);
    wait_done(ed, mode == 2);
  endtask

  initial begin
    int s, ed;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_tmo",  {31'b0, timeout_err}, 32'd0);
    check("rst_din",  {24'b0, din}, 32'd0);
    check("rst_strobes", {30'b0, in_st_ifmd, in_st_kw}, 32'd0);
    check("rst_kw55", {31'b0, kw_is_5_5}, 32'd0);
    check("rst_rd1",  {16'b0, res_rd_data1}, 32'd0);
    check("rst_rd2",  {16'b0, res_rd_data2}, 32'd0);

    // Ramp source, 3x3 then 5x5 with k / -k results.
    load_src(1'b1);
    full_job(1'b0, 0, 100, 1'b0);
    readback(36);
    full_job(1'b1, 0, 0, 1'b0);
    readback(16);

    // Random source, bursty result stream of 40 words (only 36 kept).
    load_src(1'b0);
    full_job(1'b0, 1, 0, 1'b0);
    readback(36);

    // No result stream: timeout; result RAMs must be untouched.
    full_job(1'b1, 2, 0, 1'b0);
    readback(36);

    // start and source writes while busy are ignored.
    start_job(1'b0, 1'b0, s);
    wait_until(s + 50);
    start     = 1'b1;
    src_we    = 1'b1;
    src_addr  = 8'd10;
    src_wdata = ~src_model[10];
    @(negedge clk);
    src_addr  = 8'd140;
    src_wdata = ~src_model[140];
    @(negedge clk);
    start  = 1'b0;
    src_we = 1'b0;
    check("busy_after_restart_try", {31'b0, busy}, 32'd1);
    drive_out(1'b0, s, 0, 500, ed);
    wait_done(ed, 1'b0);
    readback(36);
    // Second job shows the source is intact; also writes addr 5 with start.
    full_job(1'b1, 0, 900, 1'b1);
    readback(16);

    // Reset at cycle 60 of the IFMD stream, then a clean job.
    start_job(1'b0, 1'b0, s);
    wait_until(s + 62);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ifmd", {31'b0, in_st_ifmd}, 32'd0);
    check("midrst_kw",   {31'b0, in_st_kw}, 32'd0);
    check("midrst_din",  {24'b0, din}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("idle_after_rst", {30'b0, in_st_ifmd, busy}, 32'd0);
    full_job(1'b0, 1, 0, 1'b0);
    readback(36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
